// File: rtl/uart_tx_frame.sv
// UART transmitter: valid/ready byte intake into a one-entry holding register,
// then start bit, LSB-first data, optional parity and stop bits on a registered line.
module uart_tx_frame #(
  parameter int CLKS_PER_BIT = 10,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_EN    = 1,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 2
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [DATA_BITS-1:0] din,
  input  logic                 din_valid,
  output logic                 din_ready,
  output logic                 dout,
  output logic                 busy,
  output logic                 tx_done
);

  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0] DATA_LAST = 3'(DATA_BITS - 1);
  localparam logic [2:0] STOP_LAST = 3'(STOP_BITS - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t                state_q, state_d;
  logic [BAUD_W-1:0]     baud_q, baud_d;
  logic [2:0]            idx_q, idx_d;
  logic [DATA_BITS-1:0]  shift_q, shift_d;
  logic [DATA_BITS-1:0]  hold_q, hold_d;
  logic                  hold_full_q, hold_full_d;
  logic                  parity_q, parity_d;
  logic                  dout_q, dout_d;
  logic                  tx_done_q, tx_done_d;
  logic                  bit_end;
  logic                  load;

  always_comb begin
    state_d     = state_q;
    baud_d      = baud_q;
    idx_d       = idx_q;
    shift_d     = shift_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    parity_d    = parity_q;
    tx_done_d   = 1'b0;
    load        = 1'b0;
    bit_end     = (baud_q == BAUD_LAST);

    if (state_q != IDLE) begin
      baud_d = bit_end ? '0 : baud_q + BAUD_W'(1);
    end

    case (state_q)
      IDLE: begin
        if (hold_full_q) load = 1'b1;
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
          idx_d   = '0;
        end
      end
      DATA: begin
        if (bit_end) begin
          if (idx_q == DATA_LAST) begin
            state_d = (PARITY_EN != 0) ? PARITY : STOP;
            idx_d   = '0;
          end else begin
            shift_d = shift_q >> 1;
            idx_d   = idx_q + 3'd1;
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          state_d = STOP;
          idx_d   = '0;
        end
      end
      STOP: begin
        if (bit_end) begin
          if (idx_q == STOP_LAST) begin
            tx_done_d = 1'b1;
            if (hold_full_q) load = 1'b1;
            else             state_d = IDLE;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // A load needs a full holding register, so it never coincides with an intake.
    if (load) begin
      shift_d     = hold_q;
      parity_d    = (^hold_q) ^ (PARITY_ODD != 0);
      hold_full_d = 1'b0;
      state_d     = START;
      baud_d      = '0;
      idx_d       = '0;
    end else if (din_valid && !hold_full_q) begin
      hold_d      = din;
      hold_full_d = 1'b1;
    end

    case (state_d)
      START:   dout_d = 1'b0;
      DATA:    dout_d = shift_d[0];
      PARITY:  dout_d = parity_d;
      default: dout_d = 1'b1;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      baud_q      <= '0;
      idx_q       <= '0;
      shift_q     <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      parity_q    <= 1'b0;
      dout_q      <= 1'b1;
      tx_done_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      baud_q      <= baud_d;
      idx_q       <= idx_d;
      shift_q     <= shift_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      parity_q    <= parity_d;
      dout_q      <= dout_d;
      tx_done_q   <= tx_done_d;
    end
  end

  assign din_ready = ~hold_full_q;
  assign dout      = dout_q;
  assign busy      = (state_q != IDLE);
  assign tx_done   = tx_done_q;

endmodule
